// File: rtl/hwpe_stream_tcdm_linear_source.sv
// hwpe_stream_tcdm_linear_source: strided TCDM load streamer with a credit-managed response FIFO feeding a HWPE-Stream
// clk_i/rst_i/clear_i: clock, async reset, sync soft clear
// req_start_i, base_addr_i, stride_i, trans_size_i, ready_start_o, done_o, busy_o: controller handshake and config
// tcdm_*: single 32-bit load port; stream_*: output HWPE-Stream
module hwpe_stream_tcdm_linear_source #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TRANS_CNT = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 req_start_i,
  input  logic [31:0]          base_addr_i,
  input  logic [31:0]          stride_i,
  input  logic [TRANS_CNT-1:0] trans_size_i,
  output logic                 ready_start_o,
  output logic                 done_o,
  output logic                 busy_o,
  output logic                 tcdm_req_o,
  input  logic                 tcdm_gnt_i,
  output logic [31:0]          tcdm_add_o,
  output logic                 tcdm_wen_o,
  output logic [3:0]           tcdm_be_o,
  output logic [31:0]          tcdm_data_o,
  input  logic [31:0]          tcdm_r_data_i,
  input  logic                 tcdm_r_valid_i,
  output logic                 stream_valid_o,
  input  logic                 stream_ready_i,
  output logic [31:0]          stream_data_o,
  output logic [3:0]           stream_strb_o
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] IDLE = 2'd0, WORKING = 2'd1, DRAIN = 2'd2;
  logic [1:0] state;
  logic [31:0] addr, stride;
  logic [TRANS_CNT-1:0] size, issue_cnt, pop_cnt;
  logic [CW-1:0] outstanding, fifo_count, out_nxt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [31:0] mem [FIFO_DEPTH];
  logic flush, done, start, gnt_fire, push, pop, last_gnt, last_pop;
  assign start = req_start_i & ready_start_o;
  assign gnt_fire = tcdm_req_o & tcdm_gnt_i;
  // after a clear, every response still in flight belongs to the aborted transfer
  assign push = tcdm_r_valid_i & ~flush & ~clear_i;
  assign pop = stream_valid_o & stream_ready_i;
  assign last_gnt = issue_cnt == size - TRANS_CNT'(1);
  assign last_pop = pop_cnt == size - TRANS_CNT'(1);
  assign out_nxt = outstanding + CW'(gnt_fire) - CW'(tcdm_r_valid_i);
  assign ready_start_o = (state == IDLE) & (outstanding == '0);
  assign busy_o = state != IDLE;
  assign done_o = done;
  // loads in flight plus buffered words never exceed the FIFO, so every response has a slot;
  // the sum only grows on a grant, which keeps req stable until it is granted
  assign tcdm_req_o = (state == WORKING) & (issue_cnt < size) &
                      (({1'b0, outstanding} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH));
  assign tcdm_add_o = addr;
  assign tcdm_wen_o = 1'b1;
  assign tcdm_be_o = 4'hF;
  assign tcdm_data_o = '0;
  assign stream_valid_o = fifo_count != '0;
  assign stream_data_o = mem[rd_ptr];
  assign stream_strb_o = 4'hF;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      addr <= '0;
      stride <= '0;
      size <= '0;
      issue_cnt <= '0;
      pop_cnt <= '0;
      outstanding <= '0;
      fifo_count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      flush <= 1'b0;
      done <= 1'b0;
    end else begin
      outstanding <= out_nxt;
      flush <= (clear_i | flush) & (out_nxt != '0);
      done <= 1'b0;
      if (clear_i) begin
        state <= IDLE;
        issue_cnt <= '0;
        pop_cnt <= '0;
        fifo_count <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr == PW'(FIFO_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr == PW'(FIFO_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
        if (gnt_fire) begin
          addr <= addr + stride;
          issue_cnt <= issue_cnt + 1'b1;
        end
        if (pop) pop_cnt <= pop_cnt + 1'b1;
        if (start) begin
          addr <= base_addr_i & ~32'h3;
          stride <= stride_i;
          size <= trans_size_i;
          issue_cnt <= '0;
          pop_cnt <= '0;
          state <= trans_size_i != '0 ? WORKING : IDLE;
          done <= trans_size_i == '0;
        end
        if (state == WORKING && gnt_fire && last_gnt) state <= DRAIN;
        if (state == DRAIN && pop && last_pop) begin
          state <= IDLE;
          done <= 1'b1;
        end
      end
    end
  always_ff @(posedge clk_i)
    if (push) mem[wr_ptr] <= tcdm_r_data_i;
  always_ff @(posedge clk_i)
    if (!rst_i && push && !pop) assert (fifo_count != CW'(FIFO_DEPTH));
endmodule
